// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// Groups the E-stage request signals and the HI/LO result/hazard signals of
// the multiply/divide sequencer into one bundle.
//   master : the pipeline side (drives start/op/A/B/md_use).
//   slave  : the sequencer (drives busy/stall/done/HI/LO).
// Signals:
//   start  - E-stage instruction is a HI/LO writer
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
//   A, B   - forwarded rs / rt operands
//   md_use - E-stage instruction belongs to the HI/LO family (incl. mfhi/mflo)
//   busy   - operation in flight
//   stall  - hold request toward the hazard unit
//   done   - one-cycle pulse, first cycle new HI/LO visible
//   HI, LO - architectural HI/LO registers
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_use;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, op, A, B, md_use,
      input  busy, stall, done, HI, LO
   );

   modport slave (
      input  start, op, A, B, md_use,
      output busy, stall, done, HI, LO
   );
endinterface : muldiv_ctrl_if

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the
// pipelined MIPS core. The arithmetic result is computed when the operation
// is accepted and parked in pending registers; a busy counter then models the
// fixed unit latency before HI/LO are updated. mthi/mtlo write immediately.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - muldiv_ctrl_if.slave (start/op/A/B/md_use in,
//           busy/stall/done/HI/LO out)
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (1..15)
//   DIV_CYCLES  - busy cycles for div/divu   (1..15)
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_ctrl_if.slave bus
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Returns {hi, lo} for a mult/multu/div/divu request. Divide by zero
   // yields {dividend, all-ones}. The signed overflow case -2^31 / -1 is
   // given the two's-complement wrap result explicitly so it never depends
   // on how the simulator treats that division.
   function automatic logic [63:0] md_compute(
      input logic [2:0]  f_op,
      input logic [31:0] f_a,
      input logic [31:0] f_b
   );
      logic signed [63:0] sprod;
      logic        [63:0] uprod;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      logic        [63:0] res;
      sa    = $signed(f_a);
      sb    = $signed(f_b);
      sprod = $signed({{32{f_a[31]}}, f_a}) * $signed({{32{f_b[31]}}, f_b});
      uprod = {32'h0000_0000, f_a} * {32'h0000_0000, f_b};
      sq    = 32'sd0;
      sr    = 32'sd0;
      res   = 64'h0;
      case (f_op)
         OP_MULT:  res = sprod;
         OP_MULTU: res = uprod;
         OP_DIV: begin
            if (f_b == 32'h0000_0000) begin
               res = {f_a, 32'hFFFF_FFFF};
            end else if ((f_a == 32'h8000_0000) && (f_b == 32'hFFFF_FFFF)) begin
               res = {32'h0000_0000, 32'h8000_0000};
            end else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = {sr, sq};
            end
         end
         OP_DIVU: begin
            if (f_b == 32'h0000_0000) begin
               res = {f_a, 32'hFFFF_FFFF};
            end else begin
               res = {f_a % f_b, f_a / f_b};
            end
         end
         default:  res = 64'h0;
      endcase
      return res;
   endfunction

   state_t      state_r, state_s;
   logic [3:0]  cnt_r, cnt_s;
   logic [31:0] pend_hi_r, pend_hi_s;
   logic [31:0] pend_lo_r, pend_lo_s;
   logic [31:0] hi_r, hi_s;
   logic [31:0] lo_r, lo_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;
   logic [63:0] result_s;
   logic        launch_op_s;

   assign result_s    = md_compute(bus.op, bus.A, bus.B);
   // op 0..3 are the multi-cycle operations.
   assign launch_op_s = bus.start & (bus.op <= OP_DIVU);

   // State, counter, pending result and HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         pend_hi_r <= 32'h0000_0000;
         pend_lo_r <= 32'h0000_0000;
         hi_r      <= 32'h0000_0000;
         lo_r      <= 32'h0000_0000;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         pend_hi_r <= pend_hi_s;
         pend_lo_r <= pend_lo_s;
         hi_r      <= hi_s;
         lo_r      <= lo_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   // Next-state logic: launch / immediate moves in IDLE, countdown in RUN.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      pend_hi_s = pend_hi_r;
      pend_lo_s = pend_lo_r;
      hi_s      = hi_r;
      lo_s      = lo_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_s = result_s[63:32];
                     pend_lo_s = result_s[31:0];
                     cnt_s     = MULT_LOAD;
                     busy_s    = 1'b1;
                     state_s   = ST_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_s = result_s[63:32];
                     pend_lo_s = result_s[31:0];
                     cnt_s     = DIV_LOAD;
                     busy_s    = 1'b1;
                     state_s   = ST_RUN;
                  end
                  OP_MTHI: hi_s = bus.A;
                  OP_MTLO: lo_s = bus.A;
                  default: hi_s = hi_r;   // reserved ops leave everything alone
               endcase
            end else begin
               busy_s = 1'b0;
            end
         end
         ST_RUN: begin
            // Any start seen here is ignored; stall holds it upstream.
            // "<= 1" also recovers if the counter were ever found at 0.
            if (cnt_r <= 4'd1) begin
               cnt_s   = 4'd0;
               hi_s    = pend_hi_r;
               lo_s    = pend_lo_r;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               state_s = ST_IDLE;
            end else begin
               cnt_s   = cnt_r - 4'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // stall also covers the launch cycle, before busy is registered.
   assign bus.stall = bus.md_use & (busy_r | launch_op_s);
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.HI    = hi_r;
   assign bus.LO    = lo_r;

endmodule : muldiv_ctrl

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core.
- Sits beside the E-stage ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models the fixed unit latency with a busy counter.
- Drives HI/LO to the M-stage HI/LO result path and raises a stall toward the hazard unit while any HI/LO-family instruction must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is a HI/LO writer (op valid); sampled each rising edge.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no effect).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- md_use  input  1  E-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- busy  output  1  operation in flight.
- stall  output  1  combinational: md_use & (busy | (start & op<=3)).
- done  output  1  one-cycle pulse, first cycle new HI/LO visible.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (reset==0, asynchronous):
  - HI=0, LO=0, busy=0, done=0.
  - counter=0, pending results=0, state=IDLE.
  - Reset mid-operation aborts the operation; HI/LO stay 0 after reset releases.
- States: IDLE, RUN.
- IDLE, start=1, op in 0..3 at edge T:
  - Compute result into pending_hi/pending_lo:
    - mult: signed 64-bit A*B; HI=upper, LO=lower.
    - multu: unsigned 64-bit A*B.
    - div: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend.
    - divu: unsigned quotient/remainder.
    - Divide by zero (div or divu): pending_hi=A, pending_lo=32'hFFFFFFFF.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from T+ until completion.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter goes 1->0, HI/LO take the pending values, busy->0, state->IDLE, done=1 for exactly that following cycle.
  - Total: busy high for exactly N cycles; new HI/LO readable in the cycle after the last busy cycle.
- mthi/mtlo (op 4/5) in IDLE with start=1: HI (or LO) <= A at that edge.
  - No busy, no done.
  - The other register is unchanged.
- start while busy: ignored entirely (upstream must hold the instruction via stall). No restart and no write.
- Reserved op 6/7 with start=1: no state change.
- Completion edge with start=1 in the same cycle: completion takes effect. The start is ignored because busy was 1 in that cycle. stall was high, so the instruction is re-presented next cycle.
- stall:
  - Covers mfhi/mflo during busy.
  - Also covers a HI/LO-family instruction in the cycle a mult/div launches: that is stall=1 when start & op<=3, since busy is not yet set.
  - The launching instruction itself sees stall=1 in the start cycle. The hazard unit qualifies stall with "E instr is not the one being launched", or the launching instruction advances because start is registered regardless of stall. Decided: start is accepted regardless of stall.
- HI/LO never change except at a completion edge, an mthi/mtlo edge, or reset.

Test Plan:
- Reset low mid-RUN (cycle 3 of mult) -> HI=LO=0, busy=0 immediately; after release, no done pulse or HI/LO update ever appears.
- mult A=32'hFFFFFFFD (-3), B=5 -> busy high 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFF1, done pulses 1 cycle.
- multu A=32'hFFFFFFFF, B=2 -> after 5 busy cycles HI=1, LO=32'hFFFFFFFE. Separately: div A=-7, B=2 -> after 10 busy cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- divu A=7, B=0 -> after 10 cycles HI=7, LO=32'hFFFFFFFF. Separately: mthi A=32'h12345678 in IDLE -> next cycle HI=32'h12345678, LO unchanged, busy=0.
- During div busy: present md_use=1 (mflo) -> stall=1 every busy cycle, 0 in the done cycle. start=1 op=0 mid-busy -> ignored; final HI/LO equal div results and busy falls on schedule.
